// File: rtl/wb_chan_regs.sv
// Wishbone register block: per-channel RW control registers and sticky W1C event registers with IRQ.
// Define WB_CHAN_REGS_ERR_EN to answer unmapped accesses with wb_err_o instead of wb_ack_o.

module wb_chan_regs_ch #(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] CTRL_RST = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ctrl_we,
    input  logic          evt_clr,
    input  logic [DW-1:0] wr_dat,
    input  logic [DW-1:0] wr_mask,
    input  logic [DW-1:0] evt_set,
    output logic [DW-1:0] ctrl,
    output logic [DW-1:0] evt,
    output logic          irq
);
    logic [DW-1:0] clr_bits;

    assign clr_bits = evt_clr ? (wr_dat & wr_mask) : '0;

    // Clear is applied before set so a coincident event wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl <= CTRL_RST;
            evt  <= '0;
        end else begin
            if (ctrl_we) ctrl <= (ctrl & ~wr_mask) | (wr_dat & wr_mask);
            evt <= (evt & ~clr_bits) | evt_set;
        end
    end

    assign irq = |evt;
endmodule

module wb_chan_regs #(
    parameter int          NCHAN    = 4,
    parameter int          DW       = 8,
    parameter logic [31:0] CTRL_RST = '0,
    localparam int         AW       = $clog2(NCHAN) + 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [AW-1:2]       wb_adr_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    output logic                wb_stall_o,
    output logic [31:0]         wb_dat_o,
    output logic [NCHAN*DW-1:0] ctrl_o,
    output logic [NCHAN-1:0]    ctrl_wr_o,
    input  logic [NCHAN*DW-1:0] evt_i,
    output logic [NCHAN-1:0]    irq_o
);
    localparam int WAW = AW - 2;

    logic                     req_en, rd_req, wr_req;
    logic                     rd_ack_q, rd_err_q;
    logic                     wr_q;
    logic [WAW-1:0]           wr_adr_q;
    logic [DW-1:0]            wr_dat_q, wr_mask_q;
    logic [31:0]              sel_full;
    logic [31:0]              rd_word;
    logic                     rd_hit;
    logic [NCHAN-1:0]         ctrl_hit, evt_hit;
    logic                     wr_hit, wr_ack, wr_err;
    logic [NCHAN-1:0][DW-1:0] ctrl_q, evt_q;
    logic                     unused_bits;

    assign req_en = wb_cyc_i & wb_stb_i;
    assign rd_req = req_en & ~wb_we_i & ~(rd_ack_q | rd_err_q);
    assign wr_req = req_en &  wb_we_i & ~wr_q;

    assign sel_full = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (wb_adr_i == WAW'(2*i))   begin rd_word = 32'(ctrl_q[i]); rd_hit = 1'b1; end
            if (wb_adr_i == WAW'(2*i+1)) begin rd_word = 32'(evt_q[i]);  rd_hit = 1'b1; end
        end
    end

    always_comb begin
        ctrl_hit = '0;
        evt_hit  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            ctrl_hit[i] = wr_q && (wr_adr_q == WAW'(2*i));
            evt_hit[i]  = wr_q && (wr_adr_q == WAW'(2*i+1));
        end
    end

    assign wr_hit = |{ctrl_hit, evt_hit};

`ifdef WB_CHAN_REGS_ERR_EN
    assign wr_ack = wr_hit;
    assign wr_err = wr_q & ~wr_hit;
`else
    assign wr_ack = wr_q;
    assign wr_err = 1'b0;
`endif

    // Reads answer from the live address; writes are captured and decoded a cycle later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            wb_dat_o  <= '0;
            wr_q      <= 1'b0;
            wr_adr_q  <= '0;
            wr_dat_q  <= '0;
            wr_mask_q <= '0;
        end else begin
`ifdef WB_CHAN_REGS_ERR_EN
            rd_ack_q <= rd_req & rd_hit;
            rd_err_q <= rd_req & ~rd_hit;
`else
            rd_ack_q <= rd_req;
            rd_err_q <= 1'b0;
`endif
            if (rd_req) wb_dat_o <= rd_word;
            wr_q <= wr_req;
            if (wr_req) begin
                wr_adr_q  <= wb_adr_i;
                wr_dat_q  <= wb_dat_i[DW-1:0];
                wr_mask_q <= sel_full[DW-1:0];
            end
        end
    end

    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        wb_chan_regs_ch #(
            .DW       (DW),
            .CTRL_RST (CTRL_RST[DW-1:0])
        ) u_ch (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .ctrl_we  (ctrl_hit[i]),
            .evt_clr  (evt_hit[i]),
            .wr_dat   (wr_dat_q),
            .wr_mask  (wr_mask_q),
            .evt_set  (evt_i[i*DW +: DW]),
            .ctrl     (ctrl_q[i]),
            .evt      (evt_q[i]),
            .irq      (irq_o[i])
        );
    end

    assign wb_ack_o   = rd_ack_q | wr_ack;
    assign wb_err_o   = rd_err_q | wr_err;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = req_en & ~(wb_ack_o | wb_err_o);
    assign ctrl_wr_o  = ctrl_hit;
    assign ctrl_o     = ctrl_q;

    assign unused_bits = ^{wb_dat_i, sel_full, wr_hit, rd_hit};
endmodule
